n_adder: RTL and testbench



---
 rtl/alu_pkg.sv | 11 +
 rtl/n_adder_cla4.sv | 30 +++
 rtl/n_adder.sv | 82 ++++++++
 tb/tb_n_adder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: carry-lookahead group width and the group-count helper
// used to size the adder's lookahead network.
package alu_pkg;

    localparam int CLA_GROUP = 4;

    function automatic int cla_groups(input int n);
        return n / CLA_GROUP;
    endfunction

endpackage

// File: rtl/n_adder_cla4.sv
// 4-bit carry-lookahead group: local sum bits plus group generate/propagate.
// G and P never depend on c_in, so the group-level lookahead above has no loop.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       G,
    output logic       P
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = c_in;
    assign c[1] = g[0] | (p[0] & c_in);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c_in);

    assign s = p ^ c;

    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign P = &p;

endmodule

// File: rtl/n_adder.sv
// N-bit adder built from cla4 groups joined by a group-level carry lookahead,
// with combinational sum/flags and a registered copy for pipeline use.
module n_adder
    import alu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic [N-1:0] s_q,
    output logic         cout_q,
    output logic         ovf_q
);

    localparam int GROUPS = cla_groups(N);

    if ((N % CLA_GROUP) != 0 || N < CLA_GROUP) begin : g_bad_width
        $fatal(1, "n_adder: N must be a multiple of 4 and at least 4");
    end

    logic [GROUPS-1:0] grp_g;
    logic [GROUPS-1:0] grp_p;
    logic [GROUPS:0]   grp_c;
    logic              la_carry;
    logic              la_prop;
    logic              c_msb;

    for (genvar k = 0; k < GROUPS; k++) begin : g_grp
        cla4 u_cla4 (
            .a    (a[4*k +: 4]),
            .b    (b[4*k +: 4]),
            .c_in (grp_c[k]),
            .s    (s[4*k +: 4]),
            .G    (grp_g[k]),
            .P    (grp_p[k])
        );
    end

    // Each group carry is a flat sum of products over all lower groups and cin,
    // so no carry waits on the one below it.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
        grp_c    = '0;
        la_carry = 1'b0;
        la_prop  = 1'b0;
        grp_c[0] = cin;
        for (int k = 0; k < GROUPS; k++) begin
            la_carry = grp_g[k];
            la_prop  = grp_p[k];
            for (int j = k - 1; j >= 0; j--) begin
                la_carry = la_carry | (la_prop & grp_g[j]);
                la_prop  = la_prop & grp_p[j];
            end
            grp_c[k+1] = la_carry | (la_prop & cin);
        end
    end

    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c.
    assign c_msb = s[N-1] ^ a[N-1] ^ b[N-1];
    assign cout  = grp_c[GROUPS];
    assign ovf   = c_msb ^ cout;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s_q    <= s;
            cout_q <= cout;
            ovf_q  <= ovf;
        end
    end

endmodule

// File: tb/tb_n_adder.sv
// Scoreboard bench for n_adder at N=32 and N=8: immediate combinational checks,
// registered outputs checked one cycle later by an independent monitor.
module tb_n_adder;

    typedef struct packed {
        logic [31:0] s32;
        logic        c32;
        logic        o32;
        logic [7:0]  s8;
        logic        c8;
        logic        o8;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] a32, b32, s32, s_q32;
    logic        cin32, cout32, ovf32, cout_q32, ovf_q32;
    logic [7:0]  a8, b8, s8, s_q8;
    logic        cin8, cout8, ovf8, cout_q8, ovf_q8;

    exp_t sb_q[$];
    int   asserts;
    int   failures;

    n_adder #(.N(32)) dut32 (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a32),
        .b      (b32),
        .cin    (cin32),
        .s      (s32),
        .cout   (cout32),
        .ovf    (ovf32),
        .s_q    (s_q32),
        .cout_q (cout_q32),
        .ovf_q  (ovf_q32)
    );

    n_adder #(.N(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a8),
        .b      (b8),
        .cin    (cin8),
        .s      (s8),
        .cout   (cout8),
        .ovf    (ovf8),
        .s_q    (s_q8),
        .cout_q (cout_q8),
        .ovf_q  (ovf_q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain (n+1)-bit arithmetic; overflow from operand and result signs.
    task automatic ref_add(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input int n, output logic [31:0] s, output logic c, output logic o);
        longint unsigned mask, full;
        mask = (64'd1 << n) - 64'd1;
        full = (64'(a) & mask) + (64'(b) & mask) + 64'(cin);
        s    = 32'(full & mask);
        c    = full[n];
        o    = (a[n-1] == b[n-1]) && (s[n-1] != a[n-1]);
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h7F;
            3:       return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic apply(input logic [31:0] va32, input logic [31:0] vb32, input logic vc32,
                         input logic [7:0] va8, input logic [7:0] vb8, input logic vc8,
                         input logic vrst_n);
        exp_t        e;
        logic [31:0] es;
        logic        ec, eo;
        @(negedge clk);
        a32   = va32;
        b32   = vb32;
        cin32 = vc32;
        a8    = va8;
        b8    = vb8;
        cin8  = vc8;
        rst_n = vrst_n;
        #1;
        ref_add(va32, vb32, vc32, 32, es, ec, eo);
        check("s32",    64'(s32),    64'(es));
        check("cout32", 64'(cout32), 64'(ec));
        check("ovf32",  64'(ovf32),  64'(eo));
        e.s32 = es;
        e.c32 = ec;
        e.o32 = eo;
        ref_add({24'h0, va8}, {24'h0, vb8}, vc8, 8, es, ec, eo);
        check("s8",    64'(s8),    64'(es[7:0]));
        check("cout8", 64'(cout8), 64'(ec));
        check("ovf8",  64'(ovf8),  64'(eo));
        e.s8 = es[7:0];
        e.c8 = ec;
        e.o8 = eo;
        if (!vrst_n) e = '0;
        sb_q.push_back(e);
    endtask

    // Monitor: each pushed expectation is captured at the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("s_q32",    64'(s_q32),    64'(e.s32));
                check("cout_q32", 64'(cout_q32), 64'(e.c32));
                check("ovf_q32",  64'(ovf_q32),  64'(e.o32));
                check("s_q8",     64'(s_q8),     64'(e.s8));
                check("cout_q8",  64'(cout_q8),  64'(e.c8));
                check("ovf_q8",   64'(ovf_q8),   64'(e.o8));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, asserts=%0d", asserts);
        $fatal(1, "timeout");
    end

    initial begin
        asserts  = 0;
        failures = 0;
        rst_n    = 1'b0;
        a32 = '0; b32 = '0; cin32 = 1'b0;
        a8  = '0; b8  = '0; cin8  = 1'b0;

        apply(32'h1111_1111, 32'hEEEE_EEEE, 1'b0, 8'h11, 8'hEE, 1'b0, 1'b0);
        apply(32'h1111_1111, 32'hEEEE_EEEE, 1'b1, 8'h11, 8'hEE, 1'b1, 1'b0);
        apply(32'h0000_0005, 32'h0000_0003, 1'b0, 8'h05, 8'h03, 1'b0, 1'b1);
        apply(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b1);
        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        apply(32'h8000_0000, 32'h8000_0000, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1);
        apply(32'h0000_0009, ~32'h0000_0009, 1'b1, 8'h09, ~8'h09, 1'b1, 1'b1);
        apply(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 8'hEF, 8'h78, 1'b1, 1'b0);
        apply(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 8'h12, 8'h34, 1'b0, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            apply(pick32(), pick32(), 1'($urandom), pick8(), pick8(), 1'($urandom),
                  ($urandom_range(0, 63) != 0));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
